// File: rtl/if_id_skid_stage_if.sv
// IF/ID handshake bundle: IF-side valid/ready/data, ID-side valid/ready/data.
// slave  : the pipeline stage view.
// master : the surrounding environment (fetch producer plus decode consumer).
interface if_id_skid_stage_if #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INSN_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   pc_in;
  logic [INSN_W-1:0] instruction_in;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   pc_out;
  logic [INSN_W-1:0] instruction_out;

  modport slave (
    input  in_valid, pc_in, instruction_in, out_ready,
    output in_ready, out_valid, pc_out, instruction_out
  );

  modport master (
    output in_valid, pc_in, instruction_in, out_ready,
    input  in_ready, out_valid, pc_out, instruction_out
  );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline boundary with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on held state and flush/reset, never on out_ready.
// Optional macro IF_ID_PERF_EN adds the saturating stall_cycles counter.
module if_id_skid_stage #(
  parameter int unsigned       PC_W     = 64,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [INSN_W-1:0] NOP_INSN = 32'h00000013,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  if_id_skid_stage_if.slave   bus,
  output logic [1:0]          occupancy
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]    stall_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INSN_W-1:0] main_insn, skid_insn;
  logic              in_ready_int;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid;

  assign in_ready_int        = (state != FULL) && !flush && !reset;
  assign in_fire             = bus.in_valid && in_ready_int;
  assign out_fire            = (state != EMPTY) && bus.out_ready;
  assign bus.in_ready        = in_ready_int;
  assign bus.out_valid       = (state != EMPTY);
  assign bus.pc_out          = main_pc;
  assign bus.instruction_out = main_insn;

  // Next-state and data-steering decode.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    occupancy      = 2'd0;
    case (state)
      EMPTY: begin
        occupancy = 2'd0;
        if (in_fire) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        occupancy = 2'd1;
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        occupancy = 2'd2;
        if (out_fire) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (reset || flush) begin
      state_nxt = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    state <= state_nxt;
  end

  // Main and skid entry storage; reset and flush both force the NOP bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_pc   <= '0;
      main_insn <= NOP_INSN;
      skid_pc   <= '0;
      skid_insn <= NOP_INSN;
    end else begin
      if (load_main_in) begin
        main_pc   <= bus.pc_in;
        main_insn <= bus.instruction_in;
      end else if (load_main_skid) begin
        main_pc   <= skid_pc;
        main_insn <= skid_insn;
      end
      if (load_skid) begin
        skid_pc   <= bus.pc_in;
        skid_insn <= bus.instruction_in;
      end else if (load_main_skid) begin
        skid_pc   <= '0;
        skid_insn <= NOP_INSN;
      end
    end
  end

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles where IF offers an entry the stage refuses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.in_valid && !in_ready_int && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: vector table plus hand sequences.
module tb_if_id_skid_stage;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INSN_W = 32;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef IF_ID_PERF_EN
  localparam int unsigned CNT_W  = 3;
`else
  localparam int unsigned CNT_W  = 32;
`endif

  logic       clk;
  logic       reset;
  logic       flush;
  logic [1:0] occupancy;
`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
`endif

  if_id_skid_stage_if #(.PC_W(PC_W), .INSN_W(INSN_W)) bus ();

  if_id_skid_stage #(
    .PC_W    (PC_W),
    .INSN_W  (INSN_W),
    .NOP_INSN(NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [63:0] pc;
    logic        ordy;
    logic        ird;
    logic        ov;
    logic [63:0] epc;
    logic [31:0] einsn;
    logic [1:0]  eocc;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [31:0] insn_of(input logic [63:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [63:0] pc,
                     input logic ordy, input logic ird, input logic ov, input logic [63:0] epc,
                     input logic [31:0] einsn, input logic [1:0] eocc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.ird = ird; v.ov = ov; v.epc = epc; v.einsn = einsn; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [63:0] pc,
                       input logic ordy);
    reset              = rst;
    flush              = fl;
    bus.in_valid       = iv;
    bus.pc_in          = pc;
    bus.instruction_in = insn_of(pc);
    bus.out_ready      = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] q[$];
    int unsigned n;
    logic        in_acc, out_acc, ordy;

    // rst fl iv pc ordy | in_ready(pre-edge) | out_valid pc_out insn occ (post-edge)
    add(1, 0, 0, 64'h0,    0, 0, 0, 64'h0,    NOP,              0); // reset state
    add(0, 0, 1, 64'h1000, 1, 1, 1, 64'h1000, insn_of(64'h1000), 1); // streaming
    add(0, 0, 1, 64'h1004, 1, 1, 1, 64'h1004, insn_of(64'h1004), 1);
    add(0, 0, 1, 64'h1008, 1, 1, 1, 64'h1008, insn_of(64'h1008), 1);
    add(0, 0, 0, 64'h0,    1, 1, 0, 64'h1008, insn_of(64'h1008), 0); // drain holds data
    add(0, 0, 1, 64'h2000, 0, 1, 1, 64'h2000, insn_of(64'h2000), 1); // backpressure fill
    add(0, 0, 1, 64'h2004, 0, 1, 1, 64'h2000, insn_of(64'h2000), 2);
    for (int unsigned i = 0; i < 5; i++)                               // stable while FULL
      add(0, 0, 1, 64'h2008, 0, 0, 1, 64'h2000, insn_of(64'h2000), 2);
    add(0, 0, 1, 64'h2008, 1, 0, 1, 64'h2004, insn_of(64'h2004), 1); // release: skid to main
    add(0, 0, 1, 64'h2008, 1, 1, 1, 64'h2008, insn_of(64'h2008), 1);
    add(0, 0, 0, 64'h0,    1, 1, 0, 64'h2008, insn_of(64'h2008), 0);
    add(0, 0, 1, 64'h2100, 0, 1, 1, 64'h2100, insn_of(64'h2100), 1); // flush with skid held
    add(0, 0, 1, 64'h2104, 0, 1, 1, 64'h2100, insn_of(64'h2100), 2);
    add(0, 1, 1, 64'h3000, 0, 0, 0, 64'h0,    NOP,              0);
    add(0, 0, 0, 64'h0,    0, 1, 0, 64'h0,    NOP,              0);
    add(0, 0, 1, 64'h2200, 0, 1, 1, 64'h2200, insn_of(64'h2200), 1); // reset mid-operation
    add(0, 0, 1, 64'h2204, 0, 1, 1, 64'h2200, insn_of(64'h2200), 2);
    add(1, 0, 1, 64'h2208, 1, 0, 0, 64'h0,    NOP,              0);
    add(0, 0, 1, 64'h4000, 0, 1, 1, 64'h4000, insn_of(64'h4000), 1);
    add(0, 0, 0, 64'h0,    1, 1, 0, 64'h4000, insn_of(64'h4000), 0);
    add(0, 0, 1, 64'h2300, 1, 1, 1, 64'h2300, insn_of(64'h2300), 1); // flush with out_fire
    add(0, 1, 1, 64'h2304, 1, 0, 0, 64'h0,    NOP,              0);
    add(1, 1, 1, 64'h2308, 1, 0, 0, 64'h0,    NOP,              0); // reset and flush together

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(vecs[i].ird));
      step();
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_pc_out", i), bus.pc_out, vecs[i].epc);
      chk($sformatf("v%0d_insn_out", i), 64'(bus.instruction_out), 64'(vecs[i].einsn));
      chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].eocc));
    end

    // FIFO-order run with irregular out_ready against a queue model.
    drive(1, 0, 0, 64'h0, 0);
    step();
    n = 0;
    for (int c = 0; c < 60; c++) begin
      ordy = ((c % 4) != 0) && !(c >= 20 && c < 26);
      drive(0, 0, 1, 64'h5000 + 64'(4 * n), ordy);
      #1;
      chk("sb_in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      chk("sb_out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("sb_occupancy", 64'(occupancy), 64'(q.size()));
      if (q.size() != 0) begin
        chk("sb_pc_out", bus.pc_out, q[0]);
        chk("sb_insn_out", 64'(bus.instruction_out), 64'(insn_of(q[0])));
      end
      in_acc  = (q.size() < 2);
      out_acc = (q.size() != 0) && ordy;
      if (out_acc) void'(q.pop_front());
      if (in_acc) begin
        q.push_back(bus.pc_in);
        n++;
      end
      step();
    end

`ifdef IF_ID_PERF_EN
    drive(1, 0, 0, 64'h0, 0);
    step();
    chk("perf_after_reset", 64'(stall_cycles), 64'd0);
    drive(0, 0, 1, 64'h6000, 0);
    step();
    drive(0, 0, 1, 64'h6004, 0);
    step();
    chk("perf_fill_no_stall", 64'(stall_cycles), 64'd0);
    drive(0, 0, 1, 64'h6008, 0);
    for (int i = 0; i < 7; i++) step();
    chk("perf_seven", 64'(stall_cycles), 64'd7);
    for (int i = 0; i < 3; i++) step();
    chk("perf_saturate", 64'(stall_cycles), 64'd7);
    drive(0, 1, 1, 64'h6008, 0);
    step();
    chk("perf_flush_keeps", 64'(stall_cycles), 64'd7);
    drive(1, 0, 1, 64'h6008, 0);
    step();
    chk("perf_reset_clears", 64'(stall_cycles), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
Parametrised IF/ID pipeline boundary with a valid/ready handshake and a 2-entry skid buffer, replacing the plain stall/flush register.
- Accepts one fetched {pc, instruction} per cycle from IF and presents it to ID one cycle later.
- Keeps full throughput under backpressure because in_ready is a registered-state signal, not combinationally dependent on out_ready.
- Flush empties both entries and drives a NOP bubble to decode.

Parameters:
PC_W, 64, width of the program counter field
INSN_W, 32, width of the instruction field
NOP_INSN, 32'h00000013, instruction value driven while empty after reset or flush (RV addi x0,x0,0)
CNT_W, 32, width of the perf counter (used only with IF_ID_PERF_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns the block to EMPTY
flush  input  1  synchronous, drops all held and incoming entries (branch/jump redirect)
in_valid  input  1  IF presents a valid entry
in_ready  output  1  stage can accept; in_fire = in_valid & in_ready
pc_in  input  PC_W  PC of the fetched instruction
instruction_in  input  INSN_W  fetched instruction
out_valid  output  1  ID-facing entry is valid
out_ready  input  1  ID consumes; out_fire = out_valid & out_ready
pc_out  output  PC_W  PC to ID
instruction_out  output  INSN_W  instruction to ID
occupancy  output  2  number of held entries, 0..2
stall_cycles  output  CNT_W  present only with IF_ID_PERF_EN

Behaviour:
- Storage:
  - main entry: drives pc_out, instruction_out and out_valid.
  - skid entry: holds one overflow entry.
- States: EMPTY (occupancy 0), ONE (occupancy 1, main valid), FULL (occupancy 2, main and skid valid).
- in_ready = !skid_valid & !flush & !reset. Combinational from state and the flush/reset inputs only; never from out_ready.
- Transitions when neither reset nor flush is asserted:
  - EMPTY, in_fire -> ONE; main <= input.
  - EMPTY, no in_fire -> EMPTY; outputs hold.
  - ONE, in_fire & out_fire -> ONE; main <= input.
  - ONE, in_fire & !out_fire -> FULL; skid <= input; main holds.
  - ONE, !in_fire & out_fire -> EMPTY; pc_out/instruction_out hold their last values, out_valid = 0.
  - ONE, neither -> hold.
  - FULL, out_fire -> ONE; main <= skid; skid cleared. in_ready is 0 in FULL, so no input is taken in the same cycle.
  - FULL, no out_fire -> hold.
- Latency and throughput:
  - Latency: an entry accepted in cycle N is presented with out_valid = 1 in cycle N+1.
  - Throughput: 1 entry/cycle whenever out_ready stays high.
- Ordering: strict FIFO; entries are never dropped or duplicated except by flush or reset.
- Flush:
  - Next state EMPTY, out_valid = 0, pc_out = 0, instruction_out = NOP_INSN, occupancy = 0.
  - in_ready is 0 during the flush cycle, so an in_valid in that cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by ID; ID owns squashing it.
- Reset: same result as flush. Reset has priority over flush, and over any in-flight skid content mid-operation. The perf counter is also cleared (see below).
- Out-of-reset values: out_valid 0, pc_out 0, instruction_out NOP_INSN, occupancy 0, in_ready 1 from the first cycle after reset deasserts.
- Stable-while-waiting: while out_valid = 1 and out_ready = 0, pc_out and instruction_out must not change.

Optional Feature:
IF_ID_PERF_EN
- Defined:
  - Adds output port stall_cycles [CNT_W-1:0].
  - Increments by 1 each cycle with in_valid = 1, in_ready = 0, flush = 0 and reset = 0.
  - Saturates at all-ones; no wrap.
  - Cleared to 0 by reset only; flush does not affect it.
- Undefined: the port and counter logic do not exist; all other behaviour is identical.

Test Plan:
- Streaming: reset, then in_valid = 1 with pc 0x1000, 0x1004, 0x1008 on consecutive cycles and out_ready = 1 throughout -> out_valid rises the cycle after the first accept; outputs follow in order; occupancy stays at 1; in_ready stays 1.
- Backpressure fill: out_ready = 0, push pc 0x2000 then 0x2004 -> occupancy 2 and in_ready = 0. A third push of 0x2008 is held by IF. Release out_ready -> ID sees 0x2000, 0x2004, 0x2008 in order with no gaps.
- Stability: while FULL with out_ready = 0 for 5 cycles -> pc_out stays 0x2000 and instruction_out stays unchanged every cycle.
- Flush with a skid entry held: assert flush for 1 cycle with in_valid = 1 carrying pc 0x3000 -> next cycle out_valid 0, occupancy 0, instruction_out 0x00000013, pc_out 0. pc 0x3000 never appears at the output.
- Reset mid-operation: FULL state, then reset for 1 cycle -> all outputs at reset values; in_ready = 1 the cycle after reset deasserts; a new push of 0x4000 appears one cycle later.
- IF_ID_PERF_EN: hold FULL with in_valid = 1 for 7 cycles -> stall_cycles = 7. Flush -> stall_cycles still 7. Reset -> stall_cycles = 0. Force the counter to all-ones -> it saturates and does not wrap.
